// File: rtl/cpu_interlock.sv
// ============================================================================
// cpu_interlock
// ----------------------------------------------------------------------------
// Register scoreboard / issue interlock for an in-order pipeline.
//
// Each of the 16 architectural registers has a 2-bit counter of writes that
// have issued but not yet retired through writeback. Decode is stalled while
// it wants to read a register with an outstanding write, or while it wants to
// add a fourth outstanding write to a register whose counter is already full.
// A flush discards every outstanding write.
//
// Optional feature (compile-time macro):
//   CPU_INTERLOCK_WB_BYPASS_EN - a read of register r does not stall when
//       exactly one write to r is outstanding and that write retires in the
//       same cycle (the writeback value is forwarded to decode).
//
// Ports:
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  asynchronous active-high reset
//   dec_valid_i  in   1  decode has an instruction requesting issue
//   dec_ra_en_i  in   1  operand A read enable
//   dec_ra_i     in   4  operand A register index
//   dec_rb_en_i  in   1  operand B read enable
//   dec_rb_i     in   4  operand B register index
//   dec_we_i     in   1  destination write enable
//   dec_wi_i     in   4  destination register index
//   wb_we_i      in   1  writeback retire enable
//   wb_wi_i      in   4  writeback register index
//   flush_i      in   1  discard all in-flight writes
//   stall_o      out  1  hold decode and fetch this cycle (combinational)
//   issue_o      out  1  instruction accepted this cycle (combinational)
//   busy_o       out 16  bit n set when register n has a pending write
//   stall_cnt_o  out 16  saturating count of stalled cycles
//   err_o        out  1  sticky: writeback retired with nothing pending
// ============================================================================
module cpu_interlock (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dec_valid_i,
    input  logic        dec_ra_en_i,
    input  logic [3:0]  dec_ra_i,
    input  logic        dec_rb_en_i,
    input  logic [3:0]  dec_rb_i,
    input  logic        dec_we_i,
    input  logic [3:0]  dec_wi_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_wi_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        issue_o,
    output logic [15:0] busy_o,
    output logic [15:0] stall_cnt_o,
    output logic        err_o
);

    localparam logic [1:0]  CNT_ZERO = 2'd0;
    localparam logic [1:0]  CNT_ONE  = 2'd1;
    localparam logic [1:0]  CNT_FULL = 2'd3;
    localparam logic [15:0] SAT_MAX  = 16'hFFFF;

    // Scoreboard state
    logic [1:0]  cnt_r [16];
    logic [15:0] busy_r;
    logic [15:0] stall_cnt_r;
    logic        err_r;

    // Combinational decode of the current request
    logic [1:0]  ra_cnt_s;
    logic [1:0]  rb_cnt_s;
    logic [1:0]  wi_cnt_s;
    logic [1:0]  wb_cnt_s;
    logic        ra_fwd_s;
    logic        rb_fwd_s;
    logic        ra_hazard_s;
    logic        rb_hazard_s;
    logic        full_hazard_s;
    logic        hazard_s;
    logic        stall_s;
    logic        issue_s;

    // Per-register update requests and next state
    logic [15:0] inc_vec_s;
    logic [15:0] dec_vec_s;
    logic [1:0]  cnt_nxt_s [16];
    logic [15:0] busy_nxt_s;
    logic        err_set_s;
    logic [15:0] stall_cnt_nxt_s;

    // Look up the counters addressed by decode and writeback.
    always_comb begin
        ra_cnt_s = cnt_r[dec_ra_i];
        rb_cnt_s = cnt_r[dec_rb_i];
        wi_cnt_s = cnt_r[dec_wi_i];
        wb_cnt_s = cnt_r[wb_wi_i];
    end

    // Writeback forwarding: a lone pending write retiring this cycle can feed
    // the reader directly, so that read need not wait for the counter to drop.
    always_comb begin
        ra_fwd_s = 1'b0;
        rb_fwd_s = 1'b0;
`ifdef CPU_INTERLOCK_WB_BYPASS_EN
        ra_fwd_s = wb_we_i && (wb_wi_i == dec_ra_i) && (ra_cnt_s == CNT_ONE);
        rb_fwd_s = wb_we_i && (wb_wi_i == dec_rb_i) && (rb_cnt_s == CNT_ONE);
`else
        ra_fwd_s = 1'b0;
        rb_fwd_s = 1'b0;
`endif
    end

    // Hazard detection and the issue/stall handshake.
    always_comb begin
        ra_hazard_s   = dec_ra_en_i && (ra_cnt_s != CNT_ZERO) && !ra_fwd_s;
        rb_hazard_s   = dec_rb_en_i && (rb_cnt_s != CNT_ZERO) && !rb_fwd_s;
        full_hazard_s = dec_we_i && (wi_cnt_s == CNT_FULL);
        hazard_s      = dec_valid_i && (ra_hazard_s || rb_hazard_s || full_hazard_s);
        stall_s       = hazard_s && !flush_i;
        issue_s       = dec_valid_i && !stall_s && !flush_i;
    end

    // One-hot increment / decrement requests per register.
    always_comb begin
        inc_vec_s = 16'd0;
        dec_vec_s = 16'd0;
        if (issue_s && dec_we_i) begin
            inc_vec_s = 16'd1 << dec_wi_i;
        end else begin
            inc_vec_s = 16'd0;
        end
        if (wb_we_i) begin
            dec_vec_s = 16'd1 << wb_wi_i;
        end else begin
            dec_vec_s = 16'd0;
        end
    end

    // Next counter values. A flush wins over everything; an issue and a
    // retire to the same register cancel each other out. A retire against an
    // empty counter leaves it at zero (the error path records it instead).
    always_comb begin
        for (int n = 0; n < 16; n++) begin
            cnt_nxt_s[n] = cnt_r[n];
            if (flush_i) begin
                cnt_nxt_s[n] = CNT_ZERO;
            end else if (inc_vec_s[n] && dec_vec_s[n]) begin
                cnt_nxt_s[n] = cnt_r[n];
            end else if (inc_vec_s[n]) begin
                cnt_nxt_s[n] = cnt_r[n] + CNT_ONE;
            end else if (dec_vec_s[n] && (cnt_r[n] != CNT_ZERO)) begin
                cnt_nxt_s[n] = cnt_r[n] - CNT_ONE;
            end else begin
                cnt_nxt_s[n] = cnt_r[n];
            end
            busy_nxt_s[n] = (cnt_nxt_s[n] != CNT_ZERO);
        end
    end

    // Unmatched retire detection and stall counter saturation.
    always_comb begin
        err_set_s       = !flush_i && wb_we_i && (wb_cnt_s == CNT_ZERO);
        stall_cnt_nxt_s = stall_cnt_r;
        if (stall_s && (stall_cnt_r != SAT_MAX)) begin
            stall_cnt_nxt_s = stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // Scoreboard counters and busy mirror; reset discards all in-flight state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < 16; n++) begin
                cnt_r[n] <= CNT_ZERO;
            end
            busy_r <= 16'd0;
        end else begin
            for (int n = 0; n < 16; n++) begin
                cnt_r[n] <= cnt_nxt_s[n];
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Stall statistics and the sticky error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= 16'd0;
            err_r       <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_nxt_s;
            err_r       <= err_r || err_set_s;
        end
    end

    assign stall_o     = stall_s;
    assign issue_o     = issue_s;
    assign busy_o      = busy_r;
    assign stall_cnt_o = stall_cnt_r;
    assign err_o       = err_r;

endmodule
